instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000000, instruction word inserted as a bubble.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-006 SHALL have port flush  input  1  replace IF/ID contents with a bubble.
REQ-007 SHALL have port halt  input  1  request transition to HALTED.
REQ-008 SHALL have port branch_taken  input  1  redirect to branch_target.
REQ-009 SHALL have port branch_target  input  32  branch destination byte address.
REQ-010 SHALL have port jump  input  1  redirect to jump target.
REQ-011 SHALL have port jump_index  input  26  J-format index field.
REQ-012 SHALL have port imem_addr  output  32  byte address to instruction memory.
REQ-013 SHALL have port imem_instr  input  32  combinational instruction-memory read data.
REQ-014 SHALL have port if_id_instr  output  32  registered instruction to decode.
REQ-015 SHALL have port if_id_pc_plus4  output  32  registered PC+4 of that instruction.
REQ-016 SHALL have port if_id_valid  output  1  IF/ID holds a real instruction.
REQ-017 SHALL have port fetch_count  output  32  number of valid instructions loaded into IF/ID.

Function
REQ-018 imem_addr SHALL equal the PC register combinationally, with zero added latency; instruction memory returns data in the same cycle.
REQ-019 FSM states SHALL be BOOT, RUN and HALTED; BOOT -> RUN after one clock; RUN -> HALTED when halt=1 at a clock edge; HALTED exits only via reset.
REQ-020 In BOOT the PC SHALL hold and IF/ID SHALL load a bubble.
REQ-021 In RUN, next-PC priority SHALL be branch_taken > jump > stall > PC+4.
REQ-022 Jump target SHALL be {if_id_pc_plus4[31:28], jump_index, 2'b00}.
REQ-023 Branch target bits [1:0] SHALL be forced to 2'b00.
REQ-024 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-025 IF/ID update priority SHALL be branch_taken/jump/flush (load bubble) > stall (hold) > load {imem_instr, PC+4, valid=1}.
REQ-026 A redirect SHALL override a simultaneous stall: the PC is redirected and IF/ID is loaded with a bubble.
REQ-027 A bubble SHALL set if_id_instr=NOP_WORD, if_id_pc_plus4=0 and if_id_valid=0.
REQ-028 In HALTED, the PC SHALL hold, IF/ID SHALL load a bubble every cycle, and branch, jump and stall inputs SHALL be ignored.
REQ-029 fetch_count SHALL increment by 1 on every edge that loads valid=1, and SHALL wrap at 2^32.
REQ-030 The halt edge itself SHALL load a bubble rather than a fetched instruction.

Reset
REQ-031 Asserting reset SHALL immediately force PC=RESET_PC, state=BOOT, if_id_instr=NOP_WORD, if_id_pc_plus4=0, if_id_valid=0 and fetch_count=0.
REQ-032 Reset asserted mid-stall, mid-halt or mid-redirect SHALL override all other inputs; the first clock edge after deassertion is spent in BOOT.

Structure
REQ-033 A shared package SHALL hold the state enum (BOOT/RUN/HALTED), the RESET_PC default, the NOP_WORD default and the 32-bit word width constant.
REQ-034 The IF/ID pipeline register with its load/hold/bubble control SHALL be a sub-module named if_id_reg; the PC, next-PC mux, FSM and counter SHALL remain in instruction_fetch.

Verification
REQ-035 Reset, then 4 free-run cycles -> imem_addr sequence 0,0,4,8; if_id_valid sequence 0,1,1,1; fetch_count=3.
REQ-036 stall=1 for 2 cycles at PC=8 -> imem_addr stays 8 and IF/ID holds; after release, PC advances to 12.
REQ-037 branch_taken=1 with branch_target=32'h00000043 while stall=1 -> next PC=32'h40, if_id_valid=0 next cycle.
REQ-038 jump=1, jump_index=0, if_id_pc_plus4=32'h10000024 -> next PC=32'h10000000; with branch_taken also set -> branch_target wins.
REQ-039 PC=32'hFFFFFFFC, free run -> next PC=0 with no error.
REQ-040 halt=1 in RUN, then branch_taken=1 -> PC frozen, if_id_valid=0, fetch_count constant; reset pulse -> PC=RESET_PC, state=BOOT.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage and its IF/ID register.
package instruction_fetch_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [WORD_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_e;

    // J-format target: upper nibble of the delay-slot PC, word index, byte offset 0.
    function automatic logic [WORD_W-1:0] jump_target(input logic [WORD_W-1:0] pc_plus4,
                                                      input logic [25:0]       index);
        return (pc_plus4 & 32'hF000_0000) | {4'b0000, index, 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, holds it, or collapses to a bubble.
module if_id_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  ifid_op_e          op_i,
    input  logic [WORD_W-1:0] instr_i,
    input  logic [WORD_W-1:0] pc_plus4_i,
    output logic [WORD_W-1:0] instr_o,
    output logic [WORD_W-1:0] pc_plus4_o,
    output logic              valid_o
);

    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pc_plus4_q, pc_plus4_d;
    logic              valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        unique case (op_i)
            IFID_LOAD: begin
                instr_d    = instr_i;
                pc_plus4_d = pc_plus4_i;
                valid_d    = 1'b1;
            end
            IFID_BUBBLE: begin
                instr_d    = NOP_WORD;
                pc_plus4_d = '0;
                valid_d    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q    <= NOP_WORD;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC selection, BOOT/RUN/HALTED control and fetch counter.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              halt,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_instr,
    output logic [WORD_W-1:0] if_id_instr,
    output logic [WORD_W-1:0] if_id_pc_plus4,
    output logic              if_id_valid,
    output logic [WORD_W-1:0] fetch_count
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] fetch_count_q, fetch_count_d;
    logic [WORD_W-1:0] pc_plus4;
    ifid_op_e          ifid_op;

    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_op = IFID_BUBBLE;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (halt) begin
                    // The halt edge freezes the PC and drops the word being fetched.
                    state_d = HALTED;
                end else if (branch_taken) begin
                    pc_d = branch_target & 32'hFFFF_FFFC;
                end else if (jump) begin
                    pc_d = jump_target(if_id_pc_plus4, jump_index);
                end else if (stall) begin
                    ifid_op = flush ? IFID_BUBBLE : IFID_HOLD;
                end else begin
                    pc_d    = pc_plus4;
                    ifid_op = flush ? IFID_BUBBLE : IFID_LOAD;
                end
            end
            HALTED: ;
            default: state_d = BOOT;
        endcase
    end

    assign fetch_count_d = (ifid_op == IFID_LOAD) ? fetch_count_q + 32'd1 : fetch_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;

    if_id_reg #(
        .NOP_WORD(NOP_WORD)
    ) u_if_id_reg (
        .clk_i     (clk),
        .rst_i     (reset),
        .op_i      (ifid_op),
        .instr_i   (imem_instr),
        .pc_plus4_i(pc_plus4),
        .instr_o   (if_id_instr),
        .pc_plus4_o(if_id_pc_plus4),
        .valid_o   (if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: driver queues expected post-edge state, monitor compares.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stall, flush, halt, branch_taken, jump;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] imem_addr, imem_instr, if_id_instr, if_id_pc_plus4, fetch_count;
    logic        if_id_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Instruction memory model: each address returns a distinct word.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imem_instr = mem(imem_addr);

    instruction_fetch #(
        .RESET_PC(RPC),
        .NOP_WORD(NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .halt          (halt),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .if_id_instr   (if_id_instr),
        .if_id_pc_plus4(if_id_pc_plus4),
        .if_id_valid   (if_id_valid),
        .fetch_count   (fetch_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk({e.name, ".addr"},  imem_addr,             e.addr);
        chk({e.name, ".valid"}, {31'd0, if_id_valid},  {31'd0, e.valid});
        chk({e.name, ".instr"}, if_id_instr,           e.instr);
        chk({e.name, ".pc4"},   if_id_pc_plus4,        e.pc4);
        chk({e.name, ".cnt"},   fetch_count,           e.cnt);
    endtask

    // Monitor: compares the state just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) chk_all(exp_q.pop_front());
    end

    task automatic drv(input logic st, input logic fl, input logic hl, input logic br,
                       input logic [31:0] bt, input logic jp, input logic [25:0] ji);
        stall = st; flush = fl; halt = hl; branch_taken = br;
        branch_target = bt; jump = jp; jump_index = ji;
    endtask

    task automatic tick(input string nm, input logic [31:0] a, input logic v,
                        input logic [31:0] ins, input logic [31:0] p4, input logic [31:0] c);
        exp_t e;
        e.name = nm; e.addr = a; e.valid = v; e.instr = ins; e.pc4 = p4; e.cnt = c;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_now(input string nm);
        exp_t e;
        e.name = nm; e.addr = RPC; e.valid = 1'b0; e.instr = NOP; e.pc4 = '0; e.cnt = '0;
        chk_all(e);
    endtask

    initial begin
        drv(0, 0, 0, 0, 32'h0, 0, 26'h0);
        reset = 1'b1;
        #1;
        chk_reset_now("rst_async");
        tick("rst_hold", RPC, 0, NOP, 0, 0);
        reset = 1'b0;

        // Free run from reset: BOOT edge, then three fetches.
        tick("boot",  32'h0, 0, NOP,            0,     0);
        tick("run1",  32'h4, 1, mem(32'h0),     32'h4, 1);
        tick("run2",  32'h8, 1, mem(32'h4),     32'h8, 2);
        tick("run3",  32'hC, 1, mem(32'h8),     32'hC, 3);

        // Stall holds PC and IF/ID; release resumes.
        drv(1, 0, 0, 0, 32'h0, 0, 26'h0);
        tick("stall1", 32'hC, 1, mem(32'h8), 32'hC, 3);
        tick("stall2", 32'hC, 1, mem(32'h8), 32'hC, 3);
        drv(0, 0, 0, 0, 32'h0, 0, 26'h0);
        tick("unstall", 32'h10, 1, mem(32'hC), 32'h10, 4);

        // Flush alone: PC advances, IF/ID bubbles.
        drv(0, 1, 0, 0, 32'h0, 0, 26'h0);
        tick("flush", 32'h14, 0, NOP, 0, 4);
        drv(0, 0, 0, 0, 32'h0, 0, 26'h0);
        tick("post_flush", 32'h18, 1, mem(32'h14), 32'h18, 5);

        // Branch with low bits set beats a simultaneous stall.
        drv(1, 0, 0, 1, 32'h0000_0043, 0, 26'h0);
        tick("br_stall", 32'h40, 0, NOP, 0, 5);
        drv(0, 0, 0, 0, 32'h0, 0, 26'h0);
        tick("post_br", 32'h44, 1, mem(32'h40), 32'h44, 6);

        // Set up if_id_pc_plus4 = 0x10000024, then jump with index 0.
        drv(0, 0, 0, 1, 32'h1000_0020, 0, 26'h0);
        tick("br_hi", 32'h1000_0020, 0, NOP, 0, 6);
        drv(0, 0, 0, 0, 32'h0, 0, 26'h0);
        tick("fetch_hi", 32'h1000_0024, 1, mem(32'h1000_0020), 32'h1000_0024, 7);
        drv(0, 0, 0, 0, 32'h0, 1, 26'h0);
        tick("jump0", 32'h1000_0000, 0, NOP, 0, 7);
        drv(0, 0, 0, 0, 32'h0, 0, 26'h0);
        tick("post_j0", 32'h1000_0004, 1, mem(32'h1000_0000), 32'h1000_0004, 8);
        drv(1, 0, 0, 0, 32'h0, 1, 26'h3);
        tick("jump3_stall", 32'h1000_000C, 0, NOP, 0, 8);
        drv(0, 0, 0, 1, 32'h0000_0200, 1, 26'h5);
        tick("br_over_jump", 32'h200, 0, NOP, 0, 8);

        // PC wrap at the top of the address space.
        drv(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 26'h0);
        tick("br_top", 32'hFFFF_FFFC, 0, NOP, 0, 8);
        drv(0, 0, 0, 0, 32'h0, 0, 26'h0);
        tick("wrap", 32'h0, 1, mem(32'hFFFF_FFFC), 32'h0, 9);
        tick("after_wrap", 32'h4, 1, mem(32'h0), 32'h4, 10);

        // Halt: the halt edge bubbles, later redirects and stalls are ignored.
        drv(0, 0, 1, 0, 32'h0, 0, 26'h0);
        tick("halt_edge", 32'h4, 0, NOP, 0, 10);
        drv(0, 0, 0, 1, 32'h80, 0, 26'h0);
        tick("halt_br", 32'h4, 0, NOP, 0, 10);
        drv(1, 0, 0, 0, 32'h0, 1, 26'h7);
        tick("halt_jmp", 32'h4, 0, NOP, 0, 10);
        drv(0, 0, 0, 0, 32'h0, 0, 26'h0);
        tick("halt_idle", 32'h4, 0, NOP, 0, 10);

        // Reset pulse out of HALTED with a redirect still asserted.
        drv(1, 0, 1, 1, 32'h80, 0, 26'h0);
        reset = 1'b1;
        #1;
        chk_reset_now("rst_halt");
        tick("rst_halt_hold", RPC, 0, NOP, 0, 0);
        reset = 1'b0;
        drv(0, 0, 0, 0, 32'h0, 0, 26'h0);
        tick("reboot", RPC, 0, NOP, 0, 0);
        tick("rerun", RPC + 32'd4, 1, mem(RPC), RPC + 32'd4, 1);

        // Reset mid-stall, then BOOT edge ignores the stall input.
        drv(1, 0, 0, 0, 32'h0, 0, 26'h0);
        reset = 1'b1;
        #1;
        chk_reset_now("rst_stall");
        reset = 1'b0;
        tick("boot_stall", RPC, 0, NOP, 0, 0);

        @(posedge clk);
        #3;
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
